// File: rtl/fifo_drain_packetizer_pkg.sv
// fifo_pkg: shared types and constants for the async FIFO read-side blocks.
package fifo_pkg;

  typedef enum logic {
    EMPTY,
    HOLD
  } stg_state_t;

  localparam int unsigned FIFO_DATA_W_DEF = 8;
  localparam int unsigned PKT_COUNT_W     = 16;

endpackage

// File: rtl/fifo_drain_packetizer_idle_timer.sv
// drain_idle_timer: saturating idle counter that decides when a staged word
// has waited long enough to be sealed as the last word of its packet.
module drain_idle_timer
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic clk_rd,
  input  logic rst,
  input  logic load,
  input  logic inc,
  input  logic stg_full,
  output logic timeout_hit
);

  localparam int unsigned IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] SAT = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_cnt;

  // clear on every stage load, otherwise count idle cycles up to SAT
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (load) begin
      idle_cnt <= '0;
    end else if (inc && (idle_cnt != SAT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // saturated count only advances while the FIFO is empty, so dropping the
  // empty term keeps the hit sticky if the FIFO refills before the move
  assign timeout_hit = (idle_cnt == SAT) & stg_full;

endmodule

// File: rtl/fifo_drain_packetizer.sv
// fifo_drain_packetizer: drains a show-ahead FIFO read port into a
// valid/ready stream, grouping words into BURST_LEN packets with out_last.
// Optional idle-timeout sealing is enabled by defining FIFO_DRAIN_TIMEOUT_EN.
module fifo_drain_packetizer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_W_DEF,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 8
) (
  input  logic                   clk_rd,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [PKT_COUNT_W-1:0] pkt_count
);

  localparam int unsigned PW = $clog2(BURST_LEN + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(BURST_LEN - 1);

  if ((BURST_LEN < 1) || (TIMEOUT < 1)) begin : g_param_check
    $error("fifo_drain_packetizer: BURST_LEN and TIMEOUT must be >= 1");
  end

  stg_state_t            state, state_nx;
  logic [DATA_WIDTH-1:0] stg_data;
  logic                  stg_full;
  logic [PW-1:0]         pkt_cnt;
  logic                  at_boundary;
  logic                  out_free;
  logic                  timeout_hit;
  logic                  move;
  logic                  pop;
  logic                  seal_last;

  assign stg_full    = (state == HOLD);
  assign at_boundary = (pkt_cnt == LAST_IDX);
  assign out_free    = !out_valid | out_ready;
  assign move        = stg_full & out_free & (!fifo_empty | at_boundary | timeout_hit);
  assign seal_last   = at_boundary | timeout_hit;
  assign fifo_rd_en  = !fifo_empty & (!stg_full | move) & !rst;
  assign pop         = fifo_rd_en;

`ifdef FIFO_DRAIN_TIMEOUT_EN
  drain_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_rd      (clk_rd),
    .rst         (rst),
    .load        (pop),
    .inc         (stg_full & fifo_empty & !move),
    .stg_full    (stg_full),
    .timeout_hit (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // stage state register
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // stage next state: a pop always leaves the stage occupied
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (pop) state_nx = HOLD;
      HOLD:    if (move && !pop) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase
  end

  // stage data capture on pop
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      stg_data <= '0;
    end else if (pop) begin
      stg_data <= fifo_rd_data;
    end
  end

  // output register: load on move, drop valid on a plain accept
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (move) begin
      out_data  <= stg_data;
      out_valid <= 1'b1;
      out_last  <= seal_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // words moved in the current packet
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (move) begin
      pkt_cnt <= seal_last ? '0 : pkt_cnt + 1'b1;
    end
  end

  // packets delivered downstream
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (out_valid && out_ready && out_last) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_packetizer.sv
// Testbench for fifo_drain_packetizer; adapts to FIFO_DRAIN_TIMEOUT_EN.
module tb_fifo_drain_packetizer;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int TO = 8;
`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk_rd = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [15:0]   pkt_count;

  always #5 clk_rd = ~clk_rd;

  fifo_drain_packetizer #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .clk_rd       (clk_rd),
    .rst          (rst),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .pkt_count    (pkt_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic [DW-1:0] q[$];
  beat_t         exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc_n = 0;
  int            pops = 0;
  int            accs = 0;
  int            acc_first = -1;
  int            acc_lastc = -1;
  logic          rdy_next = 1'b0;
  logic          s_pop, s_acc, s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic refresh();
    fifo_empty   = (q.size() == 0);
    fifo_rd_data = (q.size() != 0) ? q[0] : '0;
    out_ready    = rdy_next;
    #2;
    s_pop   = fifo_rd_en;
    s_valid = out_valid;
    s_ready = out_ready;
    s_acc   = out_valid & out_ready;
    s_data  = out_data;
    s_last  = out_last;
  endtask

  task automatic cyc();
    beat_t         b;
    logic          pv, pr, pl;
    logic [DW-1:0] pd;
    pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
    @(posedge clk_rd);
    #1;
    cyc_n++;
    if (s_pop) begin
      void'(q.pop_front());
      pops++;
    end
    if (s_acc) begin
      accs++;
      if (acc_first < 0) acc_first = cyc_n;
      acc_lastc = cyc_n;
      chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat_data", 32'(s_data), 32'(b.d));
        chk("beat_last", 32'(s_last), 32'(b.l));
      end
    end
    if (!rst && pv && !pr) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(pd));
      chk("stall_last", 32'(out_last), 32'(pl));
    end
    chk("held_words_le2", 32'((pops - accs) <= 2), 32'd1);
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy_next = 1'b0;
    q.delete();
    exp_q.delete();
    refresh();
    cyc();
    cyc();
    rst = 1'b0;
    pops = 0;
    accs = 0;
    acc_first = -1;
    acc_lastc = -1;
    refresh();
  endtask

  task automatic run_until_empty(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] w[6];
    logic [DW-1:0] rw[42];
    int            idx, gap, n, seen;

    rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    out_ready = 1'b0;

    // reset with FIFO non-empty
    q.push_back(8'h99);
    refresh();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    cyc();
    cyc();
    chk("rst_rd_en_held", 32'(fifo_rd_en), 32'd0);
    do_reset();

    // 8 preloaded words streamed back to back
    rdy_next = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q.push_back(8'(8'h10 + i));
      exp_q.push_back('{d: 8'(8'h10 + i), l: (i % BL) == BL - 1});
    end
    refresh();
    run_until_empty(40, "stream_drained");
    chk("stream_consecutive", 32'(acc_lastc - acc_first), 32'd7);
    chk("stream_pkt_count", 32'(pkt_count), 32'd2);

`ifdef FIFO_DRAIN_TIMEOUT_EN
    // lone word sealed by timeout
    do_reset();
    rdy_next = 1'b1;
    q.push_back(8'hA5);
    exp_q.push_back('{d: 8'hA5, l: 1'b1});
    refresh();
    chk("lone_pop", 32'(s_pop), 32'd1);
    repeat (TO) cyc();
    chk("lone_quiet_before", 32'(s_valid), 32'd0);
    cyc();
    chk("lone_valid", 32'(s_valid), 32'd1);
    chk("lone_last", 32'(s_last), 32'd1);
    chk("lone_data", 32'(s_data), 32'hA5);
    cyc();
    chk("lone_pkt_count", 32'(pkt_count), 32'd1);
    chk("lone_drained", 32'(exp_q.size()), 32'd0);
`endif

    // backpressure: only two words held internally
    do_reset();
    rdy_next = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = DW'($urandom);
      q.push_back(w[i]);
    end
    refresh();
    repeat (20) cyc();
    chk("stall_pops", 32'(pops), 32'd2);
    chk("stall_out_valid", 32'(s_valid), 32'd1);
    chk("stall_out_data", 32'(s_data), 32'(w[0]));
    for (int i = 0; i < 6; i++) begin
      if (i < 5 || TO_EN) exp_q.push_back('{d: w[i], l: (i == 3) || (i == 5)});
    end
    rdy_next = 1'b1;
    run_until_empty(80, "stall_drained");
    repeat (3) cyc();
    chk("stall_pkt_count", 32'(pkt_count), TO_EN ? 32'd2 : 32'd1);

`ifdef FIFO_DRAIN_TIMEOUT_EN
    // timeout under backpressure; sticky seal after the FIFO refills
    do_reset();
    rdy_next = 1'b0;
    q.push_back(8'h55);
    refresh();
    repeat (15) cyc();
    chk("to_bp_valid", 32'(s_valid), 32'd1);
    chk("to_bp_last", 32'(s_last), 32'd1);
    chk("to_bp_data", 32'(s_data), 32'h55);
    q.push_back(8'h66);
    repeat (15) cyc();
    chk("to_bp_pops", 32'(pops), 32'd2);
    q.push_back(8'h77);
    repeat (3) cyc();
    chk("to_bp_pops_full", 32'(pops), 32'd2);
    exp_q.push_back('{d: 8'h55, l: 1'b1});
    exp_q.push_back('{d: 8'h66, l: 1'b1});
    exp_q.push_back('{d: 8'h77, l: 1'b1});
    rdy_next = 1'b1;
    run_until_empty(40, "to_bp_drained");
    chk("to_bp_pkt_count", 32'(pkt_count), 32'd3);
`else
    // without timeout a lone word waits for the next one
    do_reset();
    rdy_next = 1'b1;
    q.push_back(8'hA5);
    refresh();
    seen = 0;
    repeat (100) begin
      cyc();
      if (s_valid) seen++;
    end
    chk("notimeout_no_valid", 32'(seen), 32'd0);
    q.push_back(8'hB6);
    exp_q.push_back('{d: 8'hA5, l: 1'b0});
    run_until_empty(20, "notimeout_drained");
    chk("notimeout_pkt_count", 32'(pkt_count), 32'd0);
    chk("notimeout_pops", 32'(pops), 32'd2);
`endif

    // reset mid-packet, then randomized traffic must start a fresh packet
    do_reset();
    rdy_next = 1'b1;
    q.push_back(8'hE0);
    q.push_back(8'hE1);
    q.push_back(8'hE2);
    exp_q.push_back('{d: 8'hE0, l: 1'b0});
    exp_q.push_back('{d: 8'hE1, l: 1'b0});
    refresh();
    repeat (5) cyc();
    chk("midpkt_drained", 32'(exp_q.size()), 32'd0);
    do_reset();

    for (int i = 0; i < 42; i++) begin
      rw[i] = DW'($urandom);
      if (i < 41 || TO_EN) exp_q.push_back('{d: rw[i], l: ((i % BL) == BL - 1) || (i == 41)});
    end
    idx = 0;
    gap = 0;
    n = 0;
    while ((idx < 42 || exp_q.size() != 0) && n < 3000) begin
      if (idx < 42 && gap == 0) begin
        q.push_back(rw[idx]);
        idx++;
        gap = $urandom_range(0, 4);
      end else if (gap > 0) begin
        gap--;
      end
      rdy_next = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    chk("rnd_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) cyc();
    chk("rnd_pkt_count", 32'(pkt_count), TO_EN ? 32'd11 : 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
